// File: rtl/serial_tx_fifo_if.sv
// Byte-FIFO write side plus serial_t launch side of serial_tx_fifo.
// master = producer / serial_t environment, slave = the FIFO block.
interface serial_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                hold;
    logic [7:0]          tx_data;
    logic                tx_send;
    logic                tx_busy;

    modport master (
        output wr_data, wr_en, hold, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_send
    );

    modport slave (
        input  wr_data, wr_en, hold, tx_busy,
        output full, empty, count, overflow, tx_data, tx_send
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding serial_t: buffers bursty writes and launches
// one byte at a time, pacing on serial_t busy.
module serial_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ARM_TIMEOUT = 7
) (
    input logic             clk,
    input logic             rst,
    serial_tx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = $clog2(ARM_TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CW-1:0]       ARM_LAST = CW'(ARM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        ARM,
        DRAIN
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_n;
    logic [CW-1:0]         arm_cnt;
    logic                  push;
    logic                  pop;

    // full is the registered flag, so a same-edge pop never frees room
    assign push = bus.wr_en && !bus.full;
    assign pop  = (state == IDLE) && !bus.empty
               && !bus.tx_busy && !bus.hold;

    assign bus.count = count;

    always_comb begin
        count_n = count;
        if (push && !pop)
            count_n = count + 1'b1;
        else if (pop && !push)
            count_n = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.empty    <= 1'b1;
            bus.full     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count        <= count_n;
            bus.empty    <= (count_n == '0);
            bus.full     <= (count_n == FULL_CNT);
            bus.overflow <= bus.wr_en && bus.full;
        end
    end

    // tx_send is the registered image of LAUNCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            arm_cnt     <= '0;
            bus.tx_data <= 8'h00;
            bus.tx_send <= 1'b0;
        end else begin
            bus.tx_send <= (state == LAUNCH);
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.tx_data <= mem[rd_ptr];
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    arm_cnt <= '0;
                    state   <= ARM;
                end
                ARM: begin
                    if (bus.tx_busy)
                        state <= DRAIN;
                    else if (arm_cnt == ARM_LAST)
                        state <= IDLE;
                    else
                        arm_cnt <= arm_cnt + 1'b1;
                end
                DRAIN: begin
                    if (!bus.tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Randomized bench for serial_tx_fifo with a queue-based reference
// model, a serial_t stub and a line-level frame receiver.
module tb_serial_tx_fifo;
    localparam int T = 7;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_tx_fifo_if bus ();

    serial_tx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // serial_t stub: one bit per clock, 10-bit frame
    logic       sb_busy;
    logic [9:0] sh;
    int         left;
    bit         stuck = 1'b0;
    logic       line;

    assign line        = sb_busy ? sh[0] : 1'b1;
    assign bus.tx_busy = sb_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_busy <= 1'b0;
            left    <= 0;
            sh      <= '1;
        end else if (sb_busy) begin
            if (left == 1) begin
                sb_busy <= 1'b0;
            end else begin
                sh   <= sh >> 1;
                left <= left - 1;
            end
        end else if (bus.tx_send && !stuck) begin
            sh      <= {1'b1, bus.tx_data, 1'b0};
            left    <= 10;
            sb_busy <= 1'b1;
        end
    end

    // line receiver
    int         rcnt;
    logic [7:0] rb;
    logic [7:0] rx_q[$];
    int         frame_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= 0;
        end else if (rcnt == 0) begin
            if (!line)
                rcnt <= 1;
        end else if (rcnt < 9) begin
            rb[rcnt-1] <= line;
            rcnt       <= rcnt + 1;
        end else begin
            if (line)
                rx_q.push_back(rb);
            else
                frame_err++;
            rcnt <= 0;
        end
    end

    // reference model
    logic [7:0] q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] last = 8'h00;
    bit         inflight = 1'b0;
    bit         seen_busy = 1'b0;
    int         n0 = 0;
    int         cyc = 0;
    int         send_cyc[$];

    task automatic step(input logic we, input logic [7:0] d,
                        input logic h);
        bit pb;
        bit acc;
        bit pop_now;
        int sz;
        int k;
        bus.wr_en   = we;
        bus.wr_data = d;
        bus.hold    = h;
        pb = sb_busy;
        @(posedge clk);
        cyc++;
        #1;
        sz      = q.size();
        acc     = we && (sz < D);
        pop_now = !inflight && (sz > 0) && !pb && !h;
        if (inflight) begin
            k = cyc - n0;
            if (k >= 2) begin
                if (!seen_busy) begin
                    if (pb)
                        seen_busy = 1'b1;
                    else if (k == T + 1)
                        inflight = 1'b0;
                end else if (!pb) begin
                    inflight = 1'b0;
                end
            end
        end
        if (pop_now) begin
            last = q.pop_front();
            exp_tx_q.push_back(last);
            inflight  = 1'b1;
            seen_busy = 1'b0;
            n0        = cyc;
        end
        if (acc)
            q.push_back(d);
        chk("count", bus.count, q.size());
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == D);
        chk("overflow", bus.overflow, we && (sz == D));
        chk("tx_send", bus.tx_send, inflight && (cyc == n0 + 1));
        chk("tx_data", bus.tx_data, last);
        if (bus.tx_send)
            send_cyc.push_back(cyc);
    endtask

    task automatic drain();
        int guard = 0;
        while ((inflight || q.size() > 0 || sb_busy || rcnt != 0)
               && guard < 3000) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("drain_bound", guard < 3000, 1'b1);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic cmp_rx();
        int n;
        chk("rx_len", rx_q.size(), exp_tx_q.size());
        n = rx_q.size() < exp_tx_q.size() ? rx_q.size() : exp_tx_q.size();
        for (int i = 0; i < n; i++)
            chk("rx_byte", rx_q[i], exp_tx_q[i]);
        rx_q.delete();
        exp_tx_q.delete();
    endtask

    initial begin
        int e;
        int guard;
        logic h;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.hold    = 1'b0;
        #12;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_send", bus.tx_send, 0);
        chk("rst_data", bus.tx_data, 8'h00);
        rst = 1'b0;

        // single byte and launch latency
        send_cyc.delete();
        step(1'b1, 8'hAA, 1'b0);
        e = cyc;
        drain();
        chk("lat_pulses", send_cyc.size(), 1);
        if (send_cyc.size() > 0)
            chk("lat_edge", send_cyc[0], e + 2);
        cmp_rx();

        // burst to full, 17th write dropped
        for (int i = 1; i <= 16; i++)
            step(1'b1, 8'(i), 1'b1);
        chk("burst_full", bus.full, 1);
        step(1'b1, 8'hFF, 1'b1);
        chk("burst_ovf", bus.overflow, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("burst_ovf_pulse", bus.overflow, 0);
        drain();
        cmp_rx();

        // hold gates launches
        send_cyc.delete();
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h30 + 8'(i), 1'b1);
        for (int i = 0; i < 6; i++)
            step(1'b0, 8'h00, 1'b1);
        chk("hold_count", bus.count, 3);
        chk("hold_nosend", send_cyc.size(), 0);
        drain();
        chk("hold_pulses", send_cyc.size(), 3);
        cmp_rx();

        // push on the pop edge
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        chk("pushpop_cnt", bus.count, 1);
        drain();
        cmp_rx();

        // ARM timeout with dead serial_t
        stuck = 1'b1;
        send_cyc.delete();
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'hC0 + 8'(i), 1'b0);
        drain();
        chk("to_pulses", send_cyc.size(), 4);
        for (int i = 1; i < send_cyc.size(); i++)
            chk("to_gap", send_cyc[i] - send_cyc[i-1], T + 2);
        exp_tx_q.delete();
        chk("to_rx", rx_q.size(), 0);
        stuck = 1'b0;

        // reset mid-DRAIN with three bytes queued
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h70 + 8'(i), 1'b0);
        guard = 0;
        while (!(inflight && seen_busy && q.size() == 3) && guard < 60) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("rst_setup", guard < 60, 1'b1);
        bus.wr_en = 1'b0;
        rst = 1'b1;
        #2;
        chk("mid_count", bus.count, 0);
        chk("mid_empty", bus.empty, 1);
        chk("mid_send", bus.tx_send, 0);
        chk("mid_data", bus.tx_data, 8'h00);
        q.delete();
        inflight = 1'b0;
        last     = 8'h00;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        rx_q.delete();
        exp_tx_q.delete();
        send_cyc.delete();
        for (int i = 0; i < 30; i++)
            step(1'b0, 8'h00, 1'b0);
        chk("post_rst_quiet", send_cyc.size(), 0);

        // random traffic
        h = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0)
                h = ~h;
            step($urandom_range(0, 9) < 6, 8'($urandom), h);
        end
        drain();
        cmp_rx();

        chk("frame_err", frame_err, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
